adc3wire_config_sequencer: RTL and testbench
============================================

Name: adc3wire_config_sequencer

Overview:
- Sits between the host register interface and one ADC 3-wire serializer. Both sides use a 4-bit address and 16-bit data, with a start pulse and a level done, high when the serializer is idle.
- After reset it replays a parameterised table of ADC register writes (autoconfig).
- It then arbitrates host write requests onto the single serializer.
- It supervises every transfer with a timeout.

Parameters:
- NUM_ENTRIES, 4: number of autoconfig table entries; must be 1..16.
- INIT_TABLE, {NUM_ENTRIES{20'h0}}: packed table. Entry i is bits [20*i+19:20*i], laid out as {addr[3:0], data[15:0]}. Entry 0 is issued first.
- AUTOCONFIG, 1: 1 runs the table after reset; 0 skips it.
- STARTUP_DELAY, 256: idle cycles after reset before the first transfer, so the MMCM/ADC can come out of reset; 0 is legal.
- TIMEOUT_CYCLES, 1023: maximum cycles spent in WAIT_BUSY+WAIT_DONE per transfer.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous reset, active-high.
- host_req  in  1  level write request; host_addr and host_data must be held stable until host_ack.
- host_addr  in  4  host register address.
- host_data  in  16  host register data.
- host_ack  out  1  one-cycle pulse when the host transfer completes or times out.
- host_busy  out  1  high from acceptance of a host request through host_ack.
- rerun  in  1  one-cycle pulse; restarts autoconfig at entry 0 and clears timeout_err.
- cfg_start  out  1  one-cycle start pulse to the serializer.
- cfg_addr  out  4  serializer address, stable from cfg_start until the transfer ends.
- cfg_data  out  16  serializer data, stable from cfg_start until the transfer ends.
- cfg_done  in  1  serializer idle flag.
- auto_done  out  1  high once the table has been fully issued, or aborted.
- timeout_err  out  1  sticky; set when any transfer times out.

Behaviour:
- Reset values: state=STARTUP; delay counter=STARTUP_DELAY; index=0; all outputs 0. cfg_addr and cfg_data reset to 0.
- Reset mid-transfer aborts immediately, with no host_ack. The serializer is reset by the same wb_rst_i.
- STARTUP: count down to 0, then go to IDLE with auto_pending = AUTOCONFIG. auto_pending is also set by rerun.
- IDLE, arbitration is evaluated each cycle and requires cfg_done=1:
  - If auto_pending, load table[index] as source AUTO.
  - Otherwise, if host_req, latch host_addr/host_data as source HOST and raise host_busy.
  - The transition to ISSUE happens on the next edge.
  - Autoconfig has strict priority. A host request during autoconfig waits; it is not dropped.
- ISSUE: cfg_start=1 for exactly one cycle; clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY: wait for cfg_done=0, then go to WAIT_DONE. The serializer drops done 1 cycle after start; any latency is tolerated.
- WAIT_DONE: wait for cfg_done=1, then go to COMPLETE.
- Timeout: the counter increments in WAIT_BUSY and WAIT_DONE. When it reaches TIMEOUT_CYCLES:
  - set timeout_err and go to COMPLETE;
  - for an AUTO source, also clear auto_pending and set auto_done, abandoning the remaining entries.
- COMPLETE, HOST source: pulse host_ack and clear host_busy.
- COMPLETE, AUTO source:
  - index==NUM_ENTRIES-1: clear auto_pending, set auto_done, reset index to 0.
  - otherwise increment index.
- COMPLETE always returns to IDLE. Minimum gap between consecutive cfg_start pulses is therefore 3 cycles plus the serializer busy time.
- rerun:
  - In IDLE or STARTUP it takes effect that cycle: auto_pending=1, index=0, auto_done=0, timeout_err=0.
  - During a transfer it is registered and applied at COMPLETE. If that transfer is an autoconfig entry, the sequence restarts from entry 0.
- auto_done when AUTOCONFIG=0: goes high on leaving STARTUP.
- host_req deasserted before acceptance is ignored. host_req held high after host_ack starts a new transfer on the next IDLE cycle; the host must drop it within 1 cycle of ack.
- cfg_start is never asserted while cfg_done=0.

Test Plan:
- Autoconfig: NUM_ENTRIES=2, table {4'h0,16'h7FFF},{4'h9,16'h03FF}, STARTUP_DELAY=8, serializer model busy 40 cycles.
  - Required: first cfg_start 8–10 cycles after reset release, with addr 0/data 7FFF, then addr 9/data 03FF.
  - auto_done rises after the second transfer completes.
- Host write after auto_done: addr 4'h3, data 16'hA5A5.
  - Required: exactly one cfg_start with those values, host_busy high throughout, one host_ack pulse after cfg_done returns high.
- Host request raised during entry 0.
  - Required: entry 1 is issued before the host transfer; host_ack arrives only after the host transfer.
- Timeout: model holds cfg_done=0 forever, TIMEOUT_CYCLES=50.
  - Required: timeout_err=1 about 50 cycles after cfg_start, auto_done=1, entry 1 never issued.
  - A subsequent rerun clears timeout_err and restarts at entry 0.
- Reset mid-transfer: assert wb_rst_i during WAIT_DONE of a host transfer.
  - Required: no host_ack, all outputs 0 the next cycle, autoconfig repeats from entry 0 after STARTUP_DELAY.
- AUTOCONFIG=0.
  - Required: no cfg_start after reset; auto_done=1 after STARTUP_DELAY; a host write works normally.

Source files
------------

// File: rtl/adc3wire_config_sequencer.sv
// ============================================================================
// Module      : adc3wire_config_sequencer
// Description : Replays an ADC register table after reset, then arbitrates
//               host writes onto one 3-wire serializer with a per-transfer
//               timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc3wire_config_sequencer #(
    parameter int                        NUM_ENTRIES    = 4,
    parameter logic [20*NUM_ENTRIES-1:0] INIT_TABLE     = {NUM_ENTRIES{20'h0}},
    parameter int                        AUTOCONFIG     = 1,
    parameter int                        STARTUP_DELAY  = 256,
    parameter int                        TIMEOUT_CYCLES = 1023
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        host_req,
    input  logic [3:0]  host_addr,
    input  logic [15:0] host_data,
    output logic        host_ack,
    output logic        host_busy,
    input  logic        rerun,
    output logic        cfg_start,
    output logic [3:0]  cfg_addr,
    output logic [15:0] cfg_data,
    input  logic        cfg_done,
    output logic        auto_done,
    output logic        timeout_err
);

    localparam int   c_dly_w     = (STARTUP_DELAY > 0) ? $clog2(STARTUP_DELAY + 1) : 1;
    localparam int   c_tmo_w     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic c_auto      = (AUTOCONFIG != 0);
    localparam logic [3:0] c_last = 4'(NUM_ENTRIES - 1);

    typedef enum logic [2:0] {
        ST_STARTUP   = 3'd0,
        ST_IDLE      = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_COMPLETE  = 3'd5
    } state_t;

    state_t               state_q;
    logic [c_dly_w-1:0]   delay_q;
    logic [c_tmo_w-1:0]   tmo_q;
    logic [3:0]           index_q;
    logic                 auto_pending_q;
    logic                 src_host_q;
    logic                 aborted_q;
    logic                 rerun_pend_q;
    logic                 host_ack_q;
    logic                 host_busy_q;
    logic                 cfg_start_q;
    logic [3:0]           cfg_addr_q;
    logic [15:0]          cfg_data_q;
    logic                 auto_done_q;
    logic                 timeout_err_q;

    logic [c_tmo_w-1:0]   tmo_d;
    logic                 tmo_hit_d;
    logic                 pend_d;
    logic [3:0]           index_d;
    logic [8:0]           entry_base_d;
    logic [19:0]          entry_d;

    // A rerun seen in IDLE/STARTUP acts in the same cycle, so arbitration
    // looks at the post-rerun pending flag and index.
    always_comb begin
        tmo_d        = tmo_q + 1'b1;
        tmo_hit_d    = (tmo_d >= c_tmo_w'(TIMEOUT_CYCLES));
        pend_d       = auto_pending_q | rerun;
        index_d      = rerun ? 4'd0 : index_q;
        entry_base_d = 9'(index_d) * 9'd20;
        entry_d      = INIT_TABLE[entry_base_d +: 20];
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q        <= ST_STARTUP;
            delay_q        <= c_dly_w'(STARTUP_DELAY);
            tmo_q          <= '0;
            index_q        <= 4'd0;
            auto_pending_q <= 1'b0;
            src_host_q     <= 1'b0;
            aborted_q      <= 1'b0;
            rerun_pend_q   <= 1'b0;
            host_ack_q     <= 1'b0;
            host_busy_q    <= 1'b0;
            cfg_start_q    <= 1'b0;
            cfg_addr_q     <= 4'd0;
            cfg_data_q     <= 16'd0;
            auto_done_q    <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            cfg_start_q <= 1'b0;
            host_ack_q  <= 1'b0;

            if (rerun && (state_q == ST_ISSUE || state_q == ST_WAIT_BUSY ||
                          state_q == ST_WAIT_DONE)) begin
                rerun_pend_q <= 1'b1;
            end

            case (state_q)
                ST_STARTUP: begin
                    if (rerun) begin
                        auto_pending_q <= 1'b1;
                        index_q        <= 4'd0;
                        auto_done_q    <= 1'b0;
                        timeout_err_q  <= 1'b0;
                    end
                    if (delay_q == '0) begin
                        state_q        <= ST_IDLE;
                        auto_pending_q <= c_auto | pend_d;
                        auto_done_q    <= ~(c_auto | pend_d);
                    end else begin
                        delay_q <= delay_q - 1'b1;
                    end
                end

                ST_IDLE: begin
                    if (rerun) begin
                        auto_pending_q <= 1'b1;
                        index_q        <= 4'd0;
                        auto_done_q    <= 1'b0;
                        timeout_err_q  <= 1'b0;
                    end
                    if (cfg_done) begin
                        if (pend_d) begin
                            cfg_addr_q  <= entry_d[19:16];
                            cfg_data_q  <= entry_d[15:0];
                            src_host_q  <= 1'b0;
                            aborted_q   <= 1'b0;
                            cfg_start_q <= 1'b1;
                            state_q     <= ST_ISSUE;
                        end else if (host_req) begin
                            cfg_addr_q  <= host_addr;
                            cfg_data_q  <= host_data;
                            src_host_q  <= 1'b1;
                            aborted_q   <= 1'b0;
                            host_busy_q <= 1'b1;
                            cfg_start_q <= 1'b1;
                            state_q     <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    tmo_q   <= '0;
                    state_q <= ST_WAIT_BUSY;
                end

                ST_WAIT_BUSY, ST_WAIT_DONE: begin
                    tmo_q <= tmo_d;
                    if (state_q == ST_WAIT_BUSY && !cfg_done) begin
                        state_q <= ST_WAIT_DONE;
                    end else if (state_q == ST_WAIT_DONE && cfg_done) begin
                        state_q    <= ST_COMPLETE;
                        host_ack_q <= src_host_q;
                    end else if (tmo_hit_d) begin
                        // A stuck autoconfig entry abandons the rest of the table.
                        state_q       <= ST_COMPLETE;
                        host_ack_q    <= src_host_q;
                        timeout_err_q <= 1'b1;
                        if (!src_host_q) begin
                            auto_pending_q <= 1'b0;
                            auto_done_q    <= 1'b1;
                            aborted_q      <= 1'b1;
                        end
                    end
                end

                ST_COMPLETE: begin
                    state_q     <= ST_IDLE;
                    host_busy_q <= 1'b0;
                    if (!src_host_q) begin
                        if (aborted_q) begin
                            index_q <= 4'd0;
                        end else if (index_q == c_last) begin
                            auto_pending_q <= 1'b0;
                            auto_done_q    <= 1'b1;
                            index_q        <= 4'd0;
                        end else begin
                            index_q <= index_q + 4'd1;
                        end
                    end
                    if (rerun_pend_q || rerun) begin
                        auto_pending_q <= 1'b1;
                        index_q        <= 4'd0;
                        auto_done_q    <= 1'b0;
                        timeout_err_q  <= 1'b0;
                        rerun_pend_q   <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign host_ack    = host_ack_q;
    assign host_busy   = host_busy_q;
    assign cfg_start   = cfg_start_q;
    assign cfg_addr    = cfg_addr_q;
    assign cfg_data    = cfg_data_q;
    assign auto_done   = auto_done_q;
    assign timeout_err = timeout_err_q;

endmodule

`default_nettype wire

// File: tb/tb_adc3wire_config_sequencer.sv
// ============================================================================
// Module      : tb_adc3wire_config_sequencer
// Description : Scoreboard bench: expected serializer writes are queued by the
//               stimulus and popped by a monitor on every cfg_start.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc3wire_config_sequencer;

    localparam int          NE    = 2;
    localparam logic [39:0] TABLE = {20'h903FF, 20'h07FFF};
    localparam int          SD    = 8;
    localparam int          TMO   = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        host_req, rerun;
    logic [3:0]  host_addr;
    logic [15:0] host_data;
    logic        host_ack, host_busy, cfg_start, cfg_done, auto_done, timeout_err;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_data;

    logic        b_host_req, b_rerun;
    logic [3:0]  b_host_addr;
    logic [15:0] b_host_data;
    logic        b_host_ack, b_host_busy, b_cfg_start, b_cfg_done, b_auto_done, b_timeout_err;
    logic [3:0]  b_cfg_addr;
    logic [15:0] b_cfg_data;

    adc3wire_config_sequencer #(
        .NUM_ENTRIES(NE), .INIT_TABLE(TABLE), .AUTOCONFIG(1),
        .STARTUP_DELAY(SD), .TIMEOUT_CYCLES(TMO)
    ) u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .host_req(host_req), .host_addr(host_addr), .host_data(host_data),
        .host_ack(host_ack), .host_busy(host_busy), .rerun(rerun),
        .cfg_start(cfg_start), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_done(cfg_done), .auto_done(auto_done), .timeout_err(timeout_err)
    );

    adc3wire_config_sequencer #(
        .NUM_ENTRIES(NE), .INIT_TABLE(TABLE), .AUTOCONFIG(0),
        .STARTUP_DELAY(SD), .TIMEOUT_CYCLES(TMO)
    ) u_dut_noauto (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .host_req(b_host_req), .host_addr(b_host_addr), .host_data(b_host_data),
        .host_ack(b_host_ack), .host_busy(b_host_busy), .rerun(b_rerun),
        .cfg_start(b_cfg_start), .cfg_addr(b_cfg_addr), .cfg_data(b_cfg_data),
        .cfg_done(b_cfg_done), .auto_done(b_auto_done), .timeout_err(b_timeout_err)
    );

    // Serializer models: done drops one cycle after start, stays low for
    // busy_cycles, or forever while hang is set.
    int busy_cycles;
    bit hang;
    int ser_cnt;
    logic ser_act;
    always @(posedge clk) begin
        if (rst) begin
            cfg_done <= 1'b1; ser_act <= 1'b0; ser_cnt <= 0;
        end else if (cfg_start) begin
            cfg_done <= 1'b0; ser_act <= 1'b1; ser_cnt <= busy_cycles;
        end else if (ser_act) begin
            if (!hang && ser_cnt <= 1) begin
                cfg_done <= 1'b1; ser_act <= 1'b0;
            end else if (ser_cnt > 0) begin
                ser_cnt <= ser_cnt - 1;
            end
        end
    end

    int b_cnt;
    always @(posedge clk) begin
        if (rst) begin
            b_cfg_done <= 1'b1; b_cnt <= 0;
        end else if (b_cfg_start) begin
            b_cfg_done <= 1'b0; b_cnt <= 5;
        end else if (!b_cfg_done) begin
            if (b_cnt <= 1) b_cfg_done <= 1'b1;
            else b_cnt <= b_cnt - 1;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // Reference model: the table in issue order, and the expected write stream.
    logic [19:0] tbl [NE] = '{20'h07FFF, 20'h903FF};
    logic [20:0] exp_q[$];   // {is_host, addr, data}
    int inflight_host;
    int since_rst;
    bit first_pending;
    logic [20:0] mon_e;
    int b_starts = 0;
    logic [19:0] b_last;

    always @(posedge clk) begin
        if (rst) since_rst <= 0;
        else     since_rst <= since_rst + 1;
    end

    always @(negedge clk) begin
        if (rst) begin
            inflight_host = 0;
            first_pending = 1'b1;
        end else begin
            if (cfg_start) begin
                chk("done_at_start", 32'(cfg_done), 32'd1);
                if (first_pending) begin
                    chk_rng("startup_latency", since_rst, SD, SD + 2);
                    first_pending = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_start: got addr %0h data %0h, required no transfer",
                             cfg_addr, cfg_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("start_addr", 32'(cfg_addr), 32'(mon_e[19:16]));
                    chk("start_data", 32'(cfg_data), 32'(mon_e[15:0]));
                    if (mon_e[20]) begin
                        chk("busy_at_start", 32'(host_busy), 32'd1);
                        inflight_host++;
                    end
                end
            end
            if (host_ack) begin
                chk("ack_expected", 32'(inflight_host > 0), 32'd1);
                chk("busy_at_ack", 32'(host_busy), 32'd1);
                if (inflight_host > 0) inflight_host--;
            end
            if (b_cfg_start) begin
                b_starts++;
                b_last = {b_cfg_addr, b_cfg_data};
            end
        end
    end

    task automatic push_table();
        foreach (tbl[i]) exp_q.push_back({1'b0, tbl[i]});
    endtask

    task automatic pulse_rerun();
        rerun = 1'b1;
        @(negedge clk);
        rerun = 1'b0;
    endtask

    task automatic wait_auto_done(input string nm);
        int n = 0;
        while (!auto_done && n < 2000) begin @(negedge clk); n++; end
        chk(nm, 32'(auto_done), 32'd1);
    endtask

    task automatic wait_start(input string nm);
        int n = 0;
        while (!cfg_start && n < 300) begin @(negedge clk); n++; end
        chk(nm, 32'(cfg_start), 32'd1);
    endtask

    task automatic host_write(input logic [3:0] a, input logic [15:0] d);
        int n = 0;
        exp_q.push_back({1'b1, a, d});
        host_addr = a;
        host_data = d;
        host_req  = 1'b1;
        while (!host_ack && n < 500) begin @(negedge clk); n++; end
        chk("host_ack_seen", 32'(host_ack), 32'd1);
        host_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_start"}, 32'(cfg_start), 32'd0);
        chk({nm, "_addr_data"}, {12'd0, cfg_addr, cfg_data}, 32'd0);
        chk({nm, "_ack_busy"}, {30'd0, host_ack, host_busy}, 32'd0);
        chk({nm, "_flags"}, {30'd0, auto_done, timeout_err}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; host_req = 1'b0; host_addr = 4'd0; host_data = 16'd0; rerun = 1'b0;
        b_host_req = 1'b0; b_host_addr = 4'd0; b_host_data = 16'd0; b_rerun = 1'b0;
        busy_cycles = 40; hang = 1'b0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        chk("reset_b_auto_done", 32'(b_auto_done), 32'd0);

        // Autoconfig after reset; the no-autoconfig instance must stay silent.
        push_table();
        rst = 1'b0;
        @(negedge clk);
        chk("auto_done_early", 32'(auto_done), 32'd0);
        repeat (SD + 1) @(negedge clk);
        chk("b_auto_done_after_startup", 32'(b_auto_done), 32'd1);
        wait_auto_done("auto_done_rise");
        chk("table_all_issued", 32'(exp_q.size()), 32'd0);
        chk("done_high_at_auto_done", 32'(cfg_done), 32'd1);

        // Host writes: fixed pattern, then random ones with random busy times.
        host_write(4'h3, 16'hA5A5);
        for (int i = 0; i < 5; i++) begin
            busy_cycles = $urandom_range(1, 45);
            repeat ($urandom_range(0, 6)) @(negedge clk);
            host_write(4'($urandom), 16'($urandom));
        end
        chk("host_busy_idle", 32'(host_busy), 32'd0);

        // Host request raised during entry 0 must follow entry 1.
        busy_cycles = 40;
        push_table();
        pulse_rerun();
        wait_start("entry0_start");
        repeat (3) @(negedge clk);
        host_addr = 4'($urandom); host_data = 16'($urandom); host_req = 1'b1;
        @(negedge clk);
        host_req = 1'b0;   // short request while busy: must be ignored
        repeat (2) @(negedge clk);
        host_write(4'($urandom), 16'($urandom));
        chk("auto_done_before_host_ack", 32'(auto_done), 32'd1);
        chk("queue_empty_after_mix", 32'(exp_q.size()), 32'd0);

        // Timeout on entry 0 abandons entry 1.
        hang = 1'b1;
        exp_q.push_back({1'b0, tbl[0]});
        pulse_rerun();
        wait_start("timeout_entry0_start");
        n = 0;
        while (!timeout_err && n < 200) begin @(negedge clk); n++; end
        chk_rng("timeout_latency", n, TMO - 2, TMO + 3);
        chk("timeout_auto_done", 32'(auto_done), 32'd1);
        repeat (20) @(negedge clk);
        hang = 1'b0;
        repeat (20) @(negedge clk);
        chk("timeout_err_sticky", 32'(timeout_err), 32'd1);
        push_table();
        pulse_rerun();
        chk("rerun_clears_timeout", 32'(timeout_err), 32'd0);
        wait_auto_done("rerun_auto_done");
        chk("rerun_all_issued", 32'(exp_q.size()), 32'd0);

        // Reset during WAIT_DONE of a host write: no ack, replay after startup.
        exp_q.push_back({1'b1, 4'hC, 16'h1234});
        host_addr = 4'hC; host_data = 16'h1234; host_req = 1'b1;
        n = 0;
        while (!(inflight_host > 0 && !cfg_done) && n < 300) begin @(negedge clk); n++; end
        chk("reached_wait_done", 32'(inflight_host > 0 && !cfg_done), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1; host_req = 1'b0;
        @(negedge clk);
        chk_outputs_zero("midreset");
        push_table();
        rst = 1'b0;
        wait_auto_done("replay_auto_done");
        chk("replay_all_issued", 32'(exp_q.size()), 32'd0);

        // Host write on the no-autoconfig instance.
        chk("b_no_start_before_host", 32'(b_starts), 32'd0);
        b_host_addr = 4'($urandom); b_host_data = 16'($urandom); b_host_req = 1'b1;
        n = 0;
        while (!b_host_ack && n < 300) begin @(negedge clk); n++; end
        chk("b_host_ack", 32'(b_host_ack), 32'd1);
        b_host_req = 1'b0;
        repeat (5) @(negedge clk);
        chk("b_one_start", 32'(b_starts), 32'd1);
        chk("b_start_value", 32'(b_last), {12'd0, b_host_addr, b_host_data});

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("final_no_inflight", 32'(inflight_host), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
